// File: rtl/keccak_sponge.sv
// Keccak sponge wrapper: absorbs 32-bit message words into the rate, applies
// pad10*1 with a domain suffix, drives an external permutation core and squeezes the digest.
module keccak_sponge #(
    parameter int unsigned RATE_WORDS = 34,
    parameter int unsigned OUT_WORDS  = 8,
    parameter logic [7:0]  DSUFFIX    = 8'h06
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [31:0]   msg_data_i,
    input  logic          msg_valid_i,
    input  logic          msg_last_i,
    input  logic [2:0]    msg_bytes_i,
    output logic          msg_ready_o,
    output logic          perm_start_o,
    output logic [1599:0] perm_din_o,
    input  logic [1599:0] perm_dout_i,
    input  logic          perm_done_i,
    output logic [31:0]   dig_data_o,
    output logic          dig_valid_o,
    output logic          dig_last_o,
    input  logic          dig_ready_i,
    output logic [1:0]    dbg_state_o
);

    // Handshakes: a word moves on a rising edge where valid and ready are both high;
    // a valid source holds data/last/bytes stable until that edge.

    typedef enum logic [1:0] {
        ST_ABSORB  = 2'd0,
        ST_PERM    = 2'd1,
        ST_SQUEEZE = 2'd2
    } state_e;

    localparam int unsigned RATE_BYTES = 4 * RATE_WORDS;
    localparam int unsigned PAD_LAST   = RATE_BYTES - 1;
    localparam int unsigned WCW        = $clog2(RATE_WORDS + 1);
    localparam int unsigned OCW        = $clog2(OUT_WORDS + 1);
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(RATE_WORDS - 1);
    localparam logic [OCW-1:0] OCNT_LAST = OCW'(OUT_WORDS - 1);

    state_e          state_q, state_d;
    logic [1599:0]   s_q, s_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [OCW-1:0]  ocnt_q, ocnt_d;
    logic            final_q, final_d;
    logic            pad_pend_q, pad_pend_d;
    logic            start_q, start_d;
    logic            live_q, live_d;

    logic [2:0]      nbytes;
    logic [31:0]     word_in;
    logic [15:0]     pad_pos;

    // Bytes past the valid count of a last beat never reach the state.
    always_comb begin
        nbytes = 3'd4;
        if (msg_last_i && (msg_bytes_i < 3'd4)) begin
            nbytes = msg_bytes_i;
        end
        word_in = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nbytes) begin
                word_in[8*k +: 8] = msg_data_i[8*k +: 8];
            end
        end
        pad_pos = 16'({wcnt_q, 2'b00}) + 16'(nbytes);
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        wcnt_d     = wcnt_q;
        ocnt_d     = ocnt_q;
        final_d    = final_q;
        pad_pend_d = pad_pend_q;
        start_d    = 1'b0;
        live_d     = 1'b1;

        case (state_q)
            ST_ABSORB: begin
                if (live_q && msg_valid_i) begin
                    s_d[32*wcnt_q +: 32] = s_q[32*wcnt_q +: 32] ^ word_in;
                    wcnt_d = wcnt_q + 1'b1;
                    if (msg_last_i) begin
                        state_d = ST_PERM;
                        start_d = 1'b1;
                        if (pad_pos < 16'(RATE_BYTES)) begin
                            s_d[8*pad_pos +: 8]  = s_d[8*pad_pos +: 8] ^ DSUFFIX;
                            s_d[8*PAD_LAST +: 8] = s_d[8*PAD_LAST +: 8] ^ 8'h80;
                            final_d = 1'b1;
                        end else begin
                            // Final word filled the rate: padding needs a block of its own.
                            final_d    = 1'b0;
                            pad_pend_d = 1'b1;
                        end
                    end else if (wcnt_q == WCNT_LAST) begin
                        state_d = ST_PERM;
                        start_d = 1'b1;
                        final_d = 1'b0;
                    end
                end
            end
            ST_PERM: begin
                // A done coinciding with our own start pulse is stale and dropped.
                if (!start_q && perm_done_i) begin
                    s_d = perm_dout_i;
                    if (final_q) begin
                        state_d = ST_SQUEEZE;
                    end else if (pad_pend_q) begin
                        s_d[7:0]             = perm_dout_i[7:0] ^ DSUFFIX;
                        s_d[8*PAD_LAST +: 8] = perm_dout_i[8*PAD_LAST +: 8] ^ 8'h80;
                        pad_pend_d = 1'b0;
                        final_d    = 1'b1;
                        start_d    = 1'b1;
                    end else begin
                        state_d = ST_ABSORB;
                        wcnt_d  = '0;
                    end
                end
            end
            ST_SQUEEZE: begin
                if (dig_ready_i) begin
                    if (ocnt_q == OCNT_LAST) begin
                        state_d = ST_ABSORB;
                        s_d     = '0;
                        wcnt_d  = '0;
                        ocnt_d  = '0;
                        final_d = 1'b0;
                    end else begin
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_ABSORB;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ABSORB;
            s_q        <= '0;
            wcnt_q     <= '0;
            ocnt_q     <= '0;
            final_q    <= 1'b0;
            pad_pend_q <= 1'b0;
            start_q    <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            wcnt_q     <= wcnt_d;
            ocnt_q     <= ocnt_d;
            final_q    <= final_d;
            pad_pend_q <= pad_pend_d;
            start_q    <= start_d;
            live_q     <= live_d;
        end
    end

    assign msg_ready_o  = (state_q == ST_ABSORB) && live_q;
    assign perm_start_o = start_q;
    assign perm_din_o   = s_q;
    assign dig_valid_o  = (state_q == ST_SQUEEZE);
    assign dig_data_o   = dig_valid_o ? s_q[32*ocnt_q +: 32] : 32'h0;
    assign dig_last_o   = dig_valid_o && (ocnt_q == OCNT_LAST);
    assign dbg_state_o  = state_q;

endmodule
